// File: rtl/stage1if_pkg.sv
// rtl/stage1if_pkg.sv - shared core definitions for the instruction fetch stage
//
// Purpose: state encoding and default widths used by stage1if.
// Contents:
//   PC_W_DEF      default program counter width
//   INSTR_W_DEF   default instruction word width
//   STALL_W       width of the optional stall counter
//   state_t       fetch state encoding (IDLE, WAIT, FULL, DROP)

package stage1if_pkg;

  localparam int PC_W_DEF    = 12;
  localparam int INSTR_W_DEF = 24;
  localparam int STALL_W     = 16;

  // IDLE: nothing outstanding, output empty
  // WAIT: one request granted, response pending
  // FULL: output holds a valid instruction
  // DROP: a squashed request is still outstanding; its response is discarded
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/stage1if.sv
// rtl/stage1if.sv - instruction fetch stage with one outstanding memory request
//
// Purpose: takes a fetch address from the IA/IF latch, issues it to instruction
// memory, and presents the returned word with its pc to the next stage.
// Optional feature: define STAGE1IF_STATS_EN to add the stall_cnt output.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   pc_in, pc_valid       fetch address and its valid flag
//   pc_ready              fetch address consumed this cycle (latch enable)
//   flush                 squash held and in-flight fetch
//   imem_req/addr/gnt     memory request channel
//   imem_rvalid/rdata     memory response channel, one per grant, in order
//   instr_out, pc_out     fetched instruction and its address
//   valid_out, out_ready  output handshake
//   stall_cnt             (STAGE1IF_STATS_EN) cycles with valid_out=1, out_ready=0

module stage1if
  import stage1if_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out,
  input  logic               out_ready
`ifdef STAGE1IF_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc_q;
  logic              req_raw;
  logic              load_out;
  logic              valid_nxt;
  logic              grant;

  // Request is masked by reset so the memory port is quiet while rst_n=0.
  assign imem_req  = rst_n & req_raw;
  assign imem_addr = imem_req ? pc_in : '0;
  assign grant     = imem_req & imem_gnt;
  assign pc_ready  = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    load_out  = 1'b0;
    valid_nxt = valid_out;
    case (state)
      ST_IDLE: begin
        req_raw = pc_valid & ~flush;
      end
      ST_WAIT: begin
        if (flush) begin
          // A response arriving with the flush is simply dropped; otherwise
          // the response is still owed and must be absorbed in DROP.
          state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid) begin
          state_nxt = ST_FULL;
          load_out  = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      ST_FULL: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
        end else if (out_ready) begin
          // Draining the output frees the slot, so the next fetch may be
          // issued in the same cycle to keep one instruction per two cycles.
          req_raw   = pc_valid;
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
        end
      end
      ST_DROP: begin
        if (!flush && imem_rvalid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    if (grant) begin
      state_nxt = ST_WAIT;
    end
    if (flush) begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else if (grant) begin
      pc_q <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_nxt;
      if (load_out) begin
        instr_out <= imem_rdata;
        pc_out    <= pc_q;
      end
    end
  end

`ifdef STAGE1IF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (valid_out && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage1if.sv
// tb/tb_stage1if.sv - self-checking bench for stage1if
//
// Purpose: directed fetch scenarios with a behavioural occupancy model checked
// every cycle, plus literal expectations for the key scenarios.
// Optional feature: define STAGE1IF_STATS_EN to also check stall_cnt.

module tb_stage1if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [23:0] imem_rdata;
  logic [23:0] instr_out;
  logic [11:0] pc_out;
  logic        valid_out;
  logic        out_ready;
`ifdef STAGE1IF_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage1if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready)
`ifdef STAGE1IF_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: the stage is a single output slot plus at most one
  // outstanding fetch, which is either wanted or already squashed.
  bit          m_fetch;
  bit          m_drop;
  bit          m_slot;
  logic [11:0] m_fpc;
  logic [11:0] m_pc;
  logic [23:0] m_instr;
  int          m_stall;

  function automatic bit model_req();
    return rst_n && pc_valid && !flush && !m_fetch && !m_drop && (!m_slot || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fetch = 0; m_drop = 0; m_slot = 0; m_stall = 0;
      m_fpc = '0; m_pc = '0; m_instr = '0;
    end else begin
      bit g;
      g = model_req() && imem_gnt;
      if (m_slot && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        m_slot = 0;
        if (m_fetch) begin
          m_fetch = 0;
          m_drop  = !imem_rvalid;
        end
      end else begin
        if (m_drop && imem_rvalid) begin
          m_drop = 0;
        end else if (m_fetch && imem_rvalid) begin
          m_fetch = 0;
          m_slot  = 1;
          m_instr = imem_rdata;
          m_pc    = m_fpc;
        end else if (m_slot && out_ready) begin
          m_slot = 0;
        end
        if (g) begin
          m_fetch = 1;
          m_fpc   = pc_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_req", 32'(imem_req), 32'(model_req()));
    check("cyc_pc_ready", 32'(pc_ready), 32'(model_req() && imem_gnt));
    if (model_req()) check("cyc_addr", 32'(imem_addr), 32'(pc_in));
    check("cyc_valid", 32'(valid_out), 32'(m_slot));
    if (m_slot) begin
      check("cyc_instr", 32'(instr_out), 32'(m_instr));
      check("cyc_pc", 32'(pc_out), 32'(m_pc));
    end
`ifdef STAGE1IF_STATS_EN
    check("cyc_stall", 32'(stall_cnt), 32'(m_stall));
`endif
  end

  bit          auto_mem = 0;
  bit          last_gnt;
  logic [11:0] last_addr;

  function automatic logic [23:0] mem_word(input logic [11:0] a);
    return {~a, a};
  endfunction

  task automatic drive(input bit pv, input logic [11:0] pc, input bit fl,
                       input bit g, input bit rv, input logic [23:0] rd);
    pc_valid = pv; pc_in = pc; flush = fl; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
  endtask

  task automatic tick();
    @(negedge clk);
    last_gnt  = imem_req & imem_gnt;
    last_addr = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = last_gnt;
      imem_rdata  = mem_word(last_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int delivered;
    int last_tick;

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(1, 12'h003, 0, 1, 0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_out), 0);
    check("rst_instr", 32'(instr_out), 0);
    check("rst_pc", 32'(pc_out), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_pc_ready", 32'(pc_ready), 0);
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    rst_n = 1'b1;
    tick();

    // basic fetch
    drive(1, 12'h010, 0, 1, 0, 24'h0);
    #1;
    check("basic_req", 32'(imem_req), 1);
    check("basic_addr", 32'(imem_addr), 'h010);
    check("basic_pc_ready", 32'(pc_ready), 1);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'hABCDEF);
    tick();
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    check("basic_valid", 32'(valid_out), 1);
    check("basic_instr", 32'(instr_out), 'hABCDEF);
    check("basic_pc", 32'(pc_out), 'h010);
    tick();
    check("basic_drain", 32'(valid_out), 0);

    // backpressure: 5 stalled cycles in FULL
    out_ready = 1'b0;
    drive(1, 12'h011, 0, 1, 0, 24'h0);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'h445566);
    tick();
    drive(1, 12'h012, 0, 1, 1, 24'h999999);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(valid_out), 1);
      check("bp_instr", 32'(instr_out), 'h445566);
      check("bp_pc", 32'(pc_out), 'h011);
      check("bp_req", 32'(imem_req), 0);
      check("bp_pc_ready", 32'(pc_ready), 0);
      tick();
    end
`ifdef STAGE1IF_STATS_EN
    check("bp_stall_cnt", 32'(stall_cnt), 5);
`endif
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'(valid_out), 0);

    // flush in WAIT without rvalid -> DROP, stale response discarded
    drive(1, 12'h030, 0, 1, 0, 24'h0);
    tick();
    drive(0, 12'h0, 1, 0, 0, 24'h0);
    tick();
    drive(1, 12'h020, 0, 1, 1, 24'h123456);
    #1;
    check("drop_no_req", 32'(imem_req), 0);
    tick();
    drive(1, 12'h020, 0, 1, 0, 24'h0);
    check("drop_valid", 32'(valid_out), 0);
    #1;
    check("drop_next_req", 32'(imem_req), 1);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'h0A0B0C);
    tick();
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    check("drop_after_valid", 32'(valid_out), 1);
    check("drop_after_instr", 32'(instr_out), 'h0A0B0C);
    check("drop_after_pc", 32'(pc_out), 'h020);
    tick();

    // flush coincident with rvalid -> straight to IDLE
    drive(1, 12'h040, 0, 1, 0, 24'h0);
    tick();
    drive(0, 12'h0, 1, 0, 1, 24'h777777);
    tick();
    drive(1, 12'h041, 0, 1, 0, 24'h0);
    check("flrv_valid", 32'(valid_out), 0);
    #1;
    check("flrv_idle_req", 32'(imem_req), 1);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'h414141);
    tick();
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    check("flrv_after_pc", 32'(pc_out), 'h041);
    tick();

    // flush in FULL clears valid_out and suppresses the request
    out_ready = 1'b0;
    drive(1, 12'h050, 0, 1, 0, 24'h0);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'h505050);
    tick();
    check("flfull_valid_pre", 32'(valid_out), 1);
    drive(1, 12'h051, 1, 1, 0, 24'h0);
    #1;
    check("flfull_no_req", 32'(imem_req), 0);
    tick();
    check("flfull_valid_post", 32'(valid_out), 0);
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    out_ready = 1'b1;
    tick();

    // reset asserted in WAIT
    drive(1, 12'h060, 0, 1, 0, 24'h0);
    tick();
    drive(1, 12'hFFF, 0, 1, 0, 24'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_out), 0);
    check("arst_instr", 32'(instr_out), 0);
    check("arst_pc", 32'(pc_out), 0);
    check("arst_req", 32'(imem_req), 0);
    check("arst_pc_ready", 32'(pc_ready), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_fff_req", 32'(imem_req), 1);
    check("arst_fff_addr", 32'(imem_addr), 'hFFF);
    tick();
    drive(0, 12'h0, 0, 0, 1, 24'hFEDCBA);
    tick();
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    check("arst_fff_valid", 32'(valid_out), 1);
    check("arst_fff_instr", 32'(instr_out), 'hFEDCBA);
    check("arst_fff_pc", 32'(pc_out), 'hFFF);
    tick();

    // streaming 8 fetches through a zero-wait, one-cycle-latency memory
    auto_mem  = 1;
    issued    = 0;
    delivered = 0;
    last_tick = 0;
    drive(1, 12'h000, 0, 1, 0, 24'h0);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (last_gnt) begin
        issued++;
        pc_in    = 12'(issued);
        pc_valid = (issued < 8);
      end
      if (valid_out) begin
        check("stream_pc", 32'(pc_out), 32'(delivered));
        check("stream_instr", 32'(instr_out), 32'(mem_word(12'(delivered))));
        delivered++;
        last_tick = c;
      end
    end
    check("stream_count", 32'(delivered), 8);
    check("stream_in_time", 32'(last_tick <= 16), 1);
    auto_mem = 0;
    drive(0, 12'h0, 0, 0, 0, 24'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage1if.md
STAGE1IF -- requirements
Module: stage1if

Interface
REQ-001 SHALL have parameter INSTR_W, default 24, instruction word width.
REQ-002 SHALL have parameter PC_W, default 12, program counter width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: pc_in  in  PC_W  fetch address from the IA/IF latch.
REQ-006 SHALL have ports: pc_valid  in  1  pc_in holds a fetch to perform.
REQ-007 SHALL have ports: pc_ready  out  1  pc_in consumed this cycle; drives the IA/IF latch enable.
REQ-008 SHALL have ports: flush  in  1  squash held and in-flight fetch.
REQ-009 SHALL have ports: imem_req  out  1; imem_addr  out  PC_W; imem_gnt  in  1  request accepted.
REQ-010 SHALL have ports: imem_rvalid  in  1; imem_rdata  in  INSTR_W  response, one per grant, in order.
REQ-011 SHALL have ports: instr_out  out  INSTR_W; pc_out  out  PC_W; valid_out  out  1; out_ready  in  1  downstream accepts.

Function
REQ-012 SHALL implement states IDLE, WAIT, FULL, DROP; at most one memory request outstanding.
REQ-013 SHALL assert imem_req, with imem_addr=pc_in, when pc_valid=1 and flush=0, and either state=IDLE or (state=FULL and out_ready=1).
REQ-014 SHALL drive pc_ready = imem_req & imem_gnt, combinationally.
REQ-015 SHALL enter WAIT on a grant and capture pc_in into an internal pc register.
REQ-016 SHALL, in WAIT on imem_rvalid with flush=0, register imem_rdata into instr_out and the captured pc into pc_out, set valid_out=1 next cycle, and enter FULL.
REQ-017 SHALL hold instr_out, pc_out and valid_out stable in FULL while out_ready=0.
REQ-018 SHALL, in FULL with out_ready=1 and no grant, clear valid_out and enter IDLE; with a grant it SHALL enter WAIT.
REQ-019 SHALL sustain one instruction per two cycles with a zero-wait, one-cycle-latency memory.
REQ-020 SHALL, on flush, clear valid_out next cycle in every state and issue no request that cycle.
REQ-021 SHALL, on flush in WAIT, enter DROP if imem_rvalid=0, or IDLE (data discarded) if imem_rvalid=1 that cycle.
REQ-022 SHALL, in DROP, issue no request, discard the next imem_rvalid and then enter IDLE; a flush in DROP keeps DROP.
REQ-023 SHALL ignore imem_rvalid in IDLE and FULL.
REQ-024 SHALL keep valid_out set only in FULL.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, valid_out=0, instr_out=0, pc_out=0, the internal pc=0, and imem_req=0.
REQ-026 SHALL abandon any in-flight request on reset; after reset the memory interface is reset too, so no stale response is expected.

Configuration
REQ-027 SHALL, when macro STAGE1IF_STATS_EN is defined, add output stall_cnt  out  16, counting cycles with valid_out=1 and out_ready=0, saturating at 16'hFFFF, cleared by reset.
REQ-028 SHALL, without STAGE1IF_STATS_EN, omit the stall_cnt port and its logic entirely.

Structure
REQ-029 SHALL take the state encoding and the default widths PC_W and INSTR_W from the shared core package.
REQ-030 SHALL be a single module; no sub-module is needed.

Verification
REQ-031 Basic fetch: pc_in=12'h010, pc_valid=1, gnt=1, rvalid next cycle with 24'hABCDEF -> valid_out=1 with instr_out=24'hABCDEF and pc_out=12'h010 two cycles after the request.
REQ-032 Backpressure: out_ready=0 for 5 cycles in FULL -> outputs are stable, no imem_req, and pc_ready=0; with STATS, stall_cnt=5.
REQ-033 Flush in WAIT without rvalid -> DROP; a following rvalid with 24'h123456 -> discarded, valid_out stays 0, next request to pc 12'h020 delivered correctly.
REQ-034 Flush coincident with rvalid -> state IDLE, valid_out=0, no DROP cycle.
REQ-035 Reset asserted in WAIT -> all outputs 0 immediately (asynchronously), state IDLE, and after release a fetch of 12'hFFF proceeds normally.
REQ-036 Streaming: pc 12'h000..12'h007, out_ready=1, gnt=1, one-cycle rvalid -> 8 instructions delivered in order within 16 cycles.
